// File: rtl/mux_pkg.sv
// Shared constants, FSM encoding and channel-mask scan helper for mux_scan_nto1.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest channel mask the helper accepts; narrower masks are zero-extended.
  localparam int MAX_CH = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Next index after cur (mod n) whose mask bit is set; returns cur when none is set.
  // Descending offsets so the smallest matching offset is the final assignment.
  function automatic int next_enabled_idx(input logic [MAX_CH-1:0] mask,
                                          input int cur, input int n);
    int idx;
    next_enabled_idx = cur;
    for (int off = MAX_CH; off >= 1; off--) begin
      idx = cur + off;
      if (idx >= n) idx = idx - n;
      if (off <= n && idx >= 0 && idx < MAX_CH && mask[idx]) next_enabled_idx = idx;
    end
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 selector of WIDTH-bit channels; out-of-range index gives 0 and hit=0.
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 1,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] din,
  input  logic [SELW-1:0]    idx,
  output logic [WIDTH-1:0]   dout,
  output logic               hit
);

  logic [WIDTH-1:0] ch [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign ch[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    dout = '0;
    hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) begin
        dout = ch[k];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N:1 mux with manual select or round-robin auto-scan and valid/ready output.
// Optional channel mask enabled by defining MUX_CH_MASK_EN.
module mux_scan_nto1
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 1,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] din,
`ifdef MUX_CH_MASK_EN
  input  logic [N-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]   dout,
  output logic [SELW-1:0]    ch_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               wrap
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  state_t state_reg, state_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [SELW-1:0]  ch_reg, ch_next, ptr_reg, ptr_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;
  logic             valid_reg, valid_next, wrap_reg, wrap_next;
  logic             pass_reg, pass_next;  // pointer wrapped; next scan load starts a new pass

  logic [SELW-1:0]  mux_idx, ptr_adv, ptr_first;
  logic [WIDTH-1:0] mux_data;
  logic             mux_hit, sel_ok, ptr_ok, adv_wraps, load, scan_entry;

  assign mux_idx = (state_reg == ST_SCAN) ? ptr_reg : sel;

  mux_nto1_comb #(.N(N), .WIDTH(WIDTH), .SELW(SELW)) u_sel (
    .din  (din),
    .idx  (mux_idx),
    .dout (mux_data),
    .hit  (mux_hit)
  );

`ifdef MUX_CH_MASK_EN
  logic [MAX_CH-1:0] mask_ext;
  logic              any_en, sel_en;

  assign mask_ext = MAX_CH'(ch_mask);
  assign any_en   = |ch_mask;

  always_comb begin
    ptr_ok = 1'b0;
    sel_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ptr_reg == SELW'(k)) ptr_ok = ch_mask[k];
      if (sel == SELW'(k))     sel_en = ch_mask[k];
    end
  end

  assign ptr_adv   = SELW'(next_enabled_idx(mask_ext, int'(ptr_reg), N));
  assign adv_wraps = any_en && (ptr_adv <= ptr_reg);
  assign ptr_first = any_en ? SELW'(next_enabled_idx(mask_ext, N - 1, N)) : '0;
  assign sel_ok    = mux_hit && sel_en;
`else
  assign ptr_ok    = 1'b1;
  assign adv_wraps = (ptr_reg == SELW'(N - 1));
  assign ptr_adv   = adv_wraps ? '0 : ptr_reg + 1'b1;
  assign ptr_first = '0;
  assign sel_ok    = mux_hit;
`endif

  always_comb begin
    state_next = ST_IDLE;
    if (en) state_next = (mode == MODE_MANUAL) ? ST_MANUAL : ST_SCAN;
  end

  // en low takes priority so a pending sample is flushed at once
  assign load       = en && (state_reg != ST_IDLE) && (!valid_reg || out_ready);
  assign scan_entry = (state_next == ST_SCAN) && (state_reg != ST_SCAN);

  always_comb begin
    dout_next  = dout_reg;
    ch_next    = ch_reg;
    valid_next = valid_reg;
    wrap_next  = 1'b0;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    pass_next  = pass_reg;
    if (!en) begin
      valid_next = 1'b0;
    end else if (load) begin
      if (state_reg == ST_MANUAL) begin
        valid_next = sel_ok;
        if (sel_ok) begin
          dout_next = mux_data;
          ch_next   = sel;
        end
      end else if (ptr_ok) begin
        dout_next  = mux_data;
        ch_next    = ptr_reg;
        valid_next = 1'b1;
        wrap_next  = pass_reg;
        pass_next  = 1'b0;
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          ptr_next = ptr_adv;
          if (adv_wraps) pass_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else begin
        // pointer sits on a masked-off channel: emit nothing and move on
        valid_next = 1'b0;
        cnt_next   = '0;
        ptr_next   = ptr_adv;
        if (adv_wraps) pass_next = 1'b1;
      end
    end
    if (scan_entry) begin
      ptr_next  = ptr_first;
      cnt_next  = '0;
      pass_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dout_reg  <= '0;
      ch_reg    <= '0;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      pass_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      ch_reg    <= ch_next;
      valid_reg <= valid_next;
      wrap_reg  <= wrap_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      pass_reg  <= pass_next;
    end
  end

  assign dout      = dout_reg;
  assign ch_out    = ch_reg;
  assign out_valid = valid_reg;
  assign wrap      = wrap_reg;

endmodule
